// File: rtl/bp_be_issue_queue.sv
// bp_be_issue_queue
//   Speculative issue queue between the front-end fetch stream and back-end
//   dispatch. Three pointers (write, speculative read, commit) let issued but
//   uncommitted entries be replayed (roll_i) or discarded (clr_i) without the
//   producer resending them.
//
// Ports
//   clk_i, reset_n_i          : clock, asynchronous active-low reset
//   enq_data_i/enq_v_i        : producer payload and valid
//   enq_ready_o               : space available (registered state only)
//   issue_data_o/issue_v_o    : oldest unissued entry; data forced 0 when not valid
//   issue_yumi_i              : consumer takes the issue entry
//   deq_i                     : commit the oldest issued entry
//   roll_i                    : replay, speculative read returns to commit pointer
//   clr_i                     : flush all entries
//   spec_cnt_o                : issued but uncommitted entries
//   free_cnt_o                : free slots
//
// Handshake: an enqueue transfers on any rising edge where enq_v_i and
// enq_ready_o are both 1; enq_v_i may be raised regardless of enq_ready_o.
// issue_yumi_i may only be asserted while issue_v_o is 1 and consumes the
// entry at that edge. deq_i may only be asserted while spec_cnt_o is nonzero.
module bp_be_issue_queue #(
  parameter int data_width_p = 64,
  parameter int els_p        = 8,
  localparam int lg_els_lp   = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [data_width_p-1:0] enq_data_i,
  input  logic                    enq_v_i,
  output logic                    enq_ready_o,
  output logic [data_width_p-1:0] issue_data_o,
  output logic                    issue_v_o,
  input  logic                    issue_yumi_i,
  input  logic                    deq_i,
  input  logic                    roll_i,
  input  logic                    clr_i,
  output logic [lg_els_lp:0]      spec_cnt_o,
  output logic [lg_els_lp:0]      free_cnt_o
);

  typedef logic [lg_els_lp:0] ptr_t;

  localparam ptr_t els_cnt_lp = ptr_t'(els_p);

  logic [data_width_p-1:0] mem [els_p];

  ptr_t wptr, rptr, cptr;
  ptr_t wptr_n, rptr_n, cptr_n;
  ptr_t occupancy;

  logic full;
  logic enq_fire;
  logic yumi_ok;
  logic deq_ok;
  logic mem_we;

  // Pointers carry one extra wrap bit, so plain subtraction gives counts
  // in the range 0..els_p and full/empty are distinguishable.
  assign occupancy   = wptr - cptr;
  assign full        = (occupancy == els_cnt_lp);
  assign enq_ready_o = ~full;
  assign issue_v_o   = (rptr != wptr);
  assign spec_cnt_o  = rptr - cptr;
  assign free_cnt_o  = els_cnt_lp - occupancy;

  assign issue_data_o = issue_v_o ? mem[rptr[lg_els_lp-1:0]] : '0;

  // Illegal requests are dropped here so pointer invariants always hold.
  assign enq_fire = enq_v_i & enq_ready_o;
  assign yumi_ok  = issue_yumi_i & issue_v_o;
  assign deq_ok   = deq_i & (spec_cnt_o != '0);

  // A flush swallows a same-cycle enqueue, though the producer still sees it accepted.
  assign mem_we = enq_fire & ~clr_i;

  always_comb begin
    wptr_n = wptr;
    rptr_n = rptr;
    cptr_n = cptr;
    if (clr_i) begin
      rptr_n = wptr;
      cptr_n = wptr;
    end else if (roll_i) begin
      wptr_n = wptr + ptr_t'(enq_fire);
      cptr_n = cptr + ptr_t'(deq_ok);
      rptr_n = cptr_n;
    end else begin
      wptr_n = wptr + ptr_t'(enq_fire);
      rptr_n = rptr + ptr_t'(yumi_ok);
      cptr_n = cptr + ptr_t'(deq_ok);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wptr[lg_els_lp-1:0]] <= enq_data_i;
    end
  end

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    issue_yumi_i |-> issue_v_o);

  a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    deq_i |-> (spec_cnt_o != '0));

  a_occ_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    occupancy <= els_cnt_lp);

endmodule

// File: tb/tb_bp_be_issue_queue.sv
module tb_bp_be_issue_queue;

  localparam int dw = 64;
  localparam int els = 8;
  localparam int lg = $clog2(els);

  logic          clk_i;
  logic          reset_n_i;
  logic [dw-1:0] enq_data_i;
  logic          enq_v_i;
  logic          enq_ready_o;
  logic [dw-1:0] issue_data_o;
  logic          issue_v_o;
  logic          issue_yumi_i;
  logic          deq_i;
  logic          roll_i;
  logic          clr_i;
  logic [lg:0]   spec_cnt_o;
  logic [lg:0]   free_cnt_o;

  int tests;
  int failed;

  logic [dw-1:0] exp_q[$];

  bp_be_issue_queue #(.data_width_p(dw), .els_p(els)) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .enq_data_i(enq_data_i),
    .enq_v_i(enq_v_i),
    .enq_ready_o(enq_ready_o),
    .issue_data_o(issue_data_o),
    .issue_v_o(issue_v_o),
    .issue_yumi_i(issue_yumi_i),
    .deq_i(deq_i),
    .roll_i(roll_i),
    .clr_i(clr_i),
    .spec_cnt_o(spec_cnt_o),
    .free_cnt_o(free_cnt_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // checker
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic enq(input logic [dw-1:0] d);
    enq_data_i = d;
    enq_v_i = 1'b1;
    step();
    enq_v_i = 1'b0;
  endtask

  task automatic yumi();
    issue_yumi_i = 1'b1;
    step();
    issue_yumi_i = 1'b0;
  endtask

  task automatic clear();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int spec, input int free);
    check({tag, "_spec"}, 64'(spec_cnt_o), 64'(spec));
    check({tag, "_free"}, 64'(free_cnt_o), 64'(free));
  endtask

  initial begin
    int m_occ, m_unis, m_spec, n_sent, n_issued, cyc;
    logic e, y, d;
    tests = 0;
    failed = 0;
    reset_n_i = 1'b0;
    enq_data_i = '0;
    enq_v_i = 1'b0;
    issue_yumi_i = 1'b0;
    deq_i = 1'b0;
    roll_i = 1'b0;
    clr_i = 1'b0;
    repeat (3) step();
    reset_n_i = 1'b1;
    step();

    // reset state
    check("rst_ready", 64'(enq_ready_o), 64'd1);
    check("rst_issue_v", 64'(issue_v_o), 64'd0);
    check("rst_issue_data", issue_data_o, 64'd0);
    check_counts("rst", 0, 8);

    // fill 1..8
    for (int i = 1; i <= 8; i++) begin
      enq(64'(i));
      if (i == 1) begin
        check("fill_first_data", issue_data_o, 64'h1);
        check("fill_first_v", 64'(issue_v_o), 64'd1);
      end
    end
    check("full_ready", 64'(enq_ready_o), 64'd0);
    check_counts("full", 0, 0);

    // enqueue + commit on a full queue: enqueue refused, slot freed next cycle
    yumi();
    check("full_issue1_data", issue_data_o, 64'h2);
    check_counts("full_issue1", 1, 0);
    enq_data_i = 64'h99;
    enq_v_i = 1'b1;
    deq_i = 1'b1;
    step();
    enq_v_i = 1'b0;
    deq_i = 1'b0;
    check("full_deq_ready", 64'(enq_ready_o), 64'd1);
    check_counts("full_deq", 0, 1);
    check("full_deq_data", issue_data_o, 64'h2);
    clear();
    check("clr_empty_v", 64'(issue_v_o), 64'd0);
    check_counts("clr_empty", 0, 8);

    // issue and roll
    enq(64'hA);
    enq(64'hB);
    enq(64'hC);
    check_counts("abc", 0, 5);
    yumi();
    check("roll_y1_data", issue_data_o, 64'hB);
    yumi();
    check("roll_y2_data", issue_data_o, 64'hC);
    check_counts("roll_pre", 2, 5);
    roll_i = 1'b1;
    step();
    roll_i = 1'b0;
    check("roll_data", issue_data_o, 64'hA);
    check_counts("roll_post", 0, 5);

    // roll with same-cycle commit and yumi
    yumi();
    yumi();
    check_counts("rc_pre", 2, 5);
    deq_i = 1'b1;
    roll_i = 1'b1;
    issue_yumi_i = 1'b1;
    step();
    deq_i = 1'b0;
    roll_i = 1'b0;
    issue_yumi_i = 1'b0;
    check("rc_data", issue_data_o, 64'hB);
    check_counts("rc_post", 0, 6);

    // clear with same-cycle enqueue
    enq(64'hD);
    check_counts("clr_pre", 0, 5);
    check("clr_pre_ready", 64'(enq_ready_o), 64'd1);
    enq_data_i = 64'hF;
    enq_v_i = 1'b1;
    clr_i = 1'b1;
    step();
    enq_v_i = 1'b0;
    clr_i = 1'b0;
    check("clr_v", 64'(issue_v_o), 64'd0);
    check("clr_data", issue_data_o, 64'd0);
    check_counts("clr_post", 0, 8);
    enq(64'h11);
    check("clr_next_data", issue_data_o, 64'h11);
    clear();

    // wrap-around stream with random gaps
    m_occ = 0; m_unis = 0; m_spec = 0; n_sent = 0; n_issued = 0; cyc = 0;
    while ((n_sent < 40 || m_occ > 0) && cyc < 1000) begin
      e = (n_sent < 40) && (m_occ < 8) && ($urandom_range(0, 3) != 0);
      y = (m_unis > 0) && ($urandom_range(0, 1) == 1);
      d = (m_spec > 0) && ($urandom_range(0, 2) == 0);
      check("wrap_v", 64'(issue_v_o), 64'(m_unis > 0));
      check("wrap_ready", 64'(enq_ready_o), 64'(m_occ < 8));
      check_counts("wrap", m_spec, 8 - m_occ);
      if (y) begin
        check("wrap_order", issue_data_o, exp_q.pop_front());
        n_issued++;
      end
      enq_data_i = 64'hC000 + 64'(n_sent);
      enq_v_i = e;
      issue_yumi_i = y;
      deq_i = d;
      if (e) begin
        exp_q.push_back(64'hC000 + 64'(n_sent));
        n_sent++;
      end
      step();
      m_occ = m_occ + int'(e) - int'(d);
      m_unis = m_unis + int'(e) - int'(y);
      m_spec = m_spec + int'(y) - int'(d);
      cyc++;
    end
    enq_v_i = 1'b0;
    issue_yumi_i = 1'b0;
    deq_i = 1'b0;
    check("wrap_budget", 64'(cyc < 1000), 64'd1);
    check("wrap_issued", 64'(n_issued), 64'd40);
    check_counts("wrap_end", 0, 8);

    // async reset mid-stream
    for (int i = 0; i < 5; i++) enq(64'h21 + 64'(i));
    yumi();
    yumi();
    check_counts("ar_pre", 2, 3);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("ar_v", 64'(issue_v_o), 64'd0);
    check("ar_ready", 64'(enq_ready_o), 64'd1);
    check("ar_data", issue_data_o, 64'd0);
    check_counts("ar", 0, 8);
    #1;
    reset_n_i = 1'b1;
    step();
    enq(64'h31);
    check("ar_next_data", issue_data_o, 64'h31);
    check_counts("ar_next", 0, 7);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
